// File: rtl/rriscv_pkg.sv
// ---------------------------------------------------------------------------
// rriscv_pkg
// Shared definitions for the RV32I decode stage.
//   - XLEN            : datapath / instruction width
//   - OPC_*           : base RV32I major opcodes handled by the decoder
//   - F7_*            : funct7 encodings that matter for OP legality
//   - imm_fmt_e       : immediate / instruction format tag (R,I,S,B,U,J)
//   - stage_state_e   : handshake state of the decode stage
//   - decoded_t       : one decoded bundle (all outputs of the stage + pc)
//   - decoded_empty() : all-zero bundle carrying only a pc
// ---------------------------------------------------------------------------
package rriscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        imm_fmt_e        imm_fmt;
        logic            rf_rw;
        logic            err;
    } decoded_t;

    function automatic decoded_t decoded_empty(input logic [XLEN-1:0] pc);
        decoded_t d;
        d         = '0;
        d.imm_fmt = IMM_R;
        d.pc      = pc;
        return d;
    endfunction

endpackage

// File: rtl/instr_decode_core.sv
// ---------------------------------------------------------------------------
// instr_decode_core
// Purely combinational RV32I decoder: raw instruction + pc -> decoded_t.
// Fields not used by an instruction's format are forced to zero; illegal
// encodings yield err=1 with every field except pc zeroed.
// Configuration macro: RRISCV_M_EXT_EN (defined -> OP funct7=0000001 legal).
// Ports:
//   instruction_i  in   XLEN   raw instruction
//   pc_i           in   XLEN   instruction address (passed through)
//   decoded_o      out  decoded_t  decoded bundle
// ---------------------------------------------------------------------------
module instr_decode_core
    import rriscv_pkg::*;
(
    input  logic [XLEN-1:0] instruction_i,
    input  logic [XLEN-1:0] pc_i,
    output decoded_t        decoded_o
);

`ifdef RRISCV_M_EXT_EN
    localparam logic M_EXT_EN = 1'b1;
`else
    localparam logic M_EXT_EN = 1'b0;
`endif

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign opcode = instruction_i[6:0];
    assign rd     = instruction_i[11:7];
    assign funct3 = instruction_i[14:12];
    assign rs1    = instruction_i[19:15];
    assign rs2    = instruction_i[24:20];
    assign funct7 = instruction_i[31:25];

    assign imm_i = {{20{instruction_i[31]}}, instruction_i[31:20]};
    assign imm_s = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
    assign imm_b = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                    instruction_i[30:25], instruction_i[11:8], 1'b0};
    assign imm_u = {instruction_i[31:12], 12'b0};
    assign imm_j = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                    instruction_i[20], instruction_i[30:21], 1'b0};

    // Only base ADD/SUB-style funct7 values (plus M-ext when enabled) are legal
    // for register-register ops; SUB/SRA encoding exists only for funct3 000/101.
    logic op_legal;
    always_comb begin
        op_legal = 1'b0;
        case (funct7)
            F7_BASE:   op_legal = 1'b1;
            F7_ALT:    op_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
            F7_MULDIV: op_legal = M_EXT_EN;
            default:   op_legal = 1'b0;
        endcase
    end

    logic     legal;
    logic     writes_rd;
    decoded_t dec;

    always_comb begin
        dec        = decoded_empty(pc_i);
        legal      = 1'b1;
        writes_rd  = 1'b0;
        dec.opcode = opcode;

        case (opcode)
            OPC_OP: begin
                legal       = op_legal;
                writes_rd   = 1'b1;
                dec.imm_fmt = IMM_R;
                dec.rs1     = rs1;
                dec.rs2     = rs2;
                dec.rd      = rd;
                dec.funct3  = funct3;
                dec.funct7  = funct7;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                writes_rd   = 1'b1;
                dec.imm_fmt = IMM_I;
                dec.rs1     = rs1;
                dec.rd      = rd;
                dec.funct3  = funct3;
                dec.imm     = imm_i;
            end
            OPC_STORE: begin
                dec.imm_fmt = IMM_S;
                dec.rs1     = rs1;
                dec.rs2     = rs2;
                dec.funct3  = funct3;
                dec.imm     = imm_s;
            end
            OPC_BRANCH: begin
                dec.imm_fmt = IMM_B;
                dec.rs1     = rs1;
                dec.rs2     = rs2;
                dec.funct3  = funct3;
                dec.imm     = imm_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                writes_rd   = 1'b1;
                dec.imm_fmt = IMM_U;
                dec.rd      = rd;
                dec.imm     = imm_u;
            end
            OPC_JAL: begin
                writes_rd   = 1'b1;
                dec.imm_fmt = IMM_J;
                dec.rd      = rd;
                dec.imm     = imm_j;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        // The opcode table already implies [1:0]==2'b11; kept explicit so a
        // future compressed-opcode entry cannot slip through by accident.
        if (instruction_i[1:0] != 2'b11) begin
            legal = 1'b0;
        end

        // x0 writes are architecturally discarded, so never request a write.
        dec.rf_rw = writes_rd && (rd != 5'd0);

        if (!legal) begin
            dec     = decoded_empty(pc_i);
            dec.err = 1'b1;
        end
    end

    assign decoded_o = dec;

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered RV32I decode stage between fetch and register-file read.
// Decodes {pc, instruction} on input accept and holds the decoded bundle in a
// main register backed by a one-entry skid register, so ready_o can come
// straight from a flop. Counts accepted illegal instructions (saturating) and
// supports a pipeline flush.
// Configuration macro: RRISCV_M_EXT_EN (forwarded to instr_decode_core).
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i
//   valid_i / ready_o / instruction_i / pc_i     upstream handshake + payload
//   valid_o / ready_i                            downstream handshake
//   pc_o, opcode_o, rs1_o, rs2_o, rd_o, funct3_o, funct7_o, immediate_o,
//   imm_fmt_o, rf_rw_o, err_o                    decoded bundle
//   illegal_cnt_o                                illegal instructions accepted
// ---------------------------------------------------------------------------
module decode_stage
    import rriscv_pkg::*;
#(
    parameter int XLEN      = rriscv_pkg::XLEN,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [XLEN-1:0]      instruction_i,
    input  logic [XLEN-1:0]      pc_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [XLEN-1:0]      pc_o,
    output logic [6:0]           opcode_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
    output logic [4:0]           rd_o,
    output logic [2:0]           funct3_o,
    output logic [6:0]           funct7_o,
    output logic [XLEN-1:0]      immediate_o,
    output logic [2:0]           imm_fmt_o,
    output logic                 rf_rw_o,
    output logic                 err_o,
    output logic [ILL_CNT_W-1:0] illegal_cnt_o
);

    decoded_t dec_in;

    instr_decode_core u_core (
        .instruction_i (instruction_i),
        .pc_i          (pc_i),
        .decoded_o     (dec_in)
    );

    stage_state_e         state_q, state_d;
    decoded_t             main_q, main_d;
    decoded_t             skid_q, skid_d;
    logic                 ready_q, ready_d;
    logic [ILL_CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic pop;

    assign accept = valid_i && ready_q;
    assign pop    = (state_q != ST_EMPTY) && ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = dec_in;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (accept && pop) begin
                    main_d = dec_in;
                end else if (accept) begin
                    // Downstream stalled: park the new bundle behind the
                    // current one and close the input next cycle.
                    skid_d  = dec_in;
                    state_d = ST_SKID;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // An instruction accepted in a flush cycle is dropped, so it is not
        // counted either.
        if (accept && dec_in.err && !flush_i && (cnt_q != {ILL_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (flush_i) begin
            state_d = ST_EMPTY;
        end

        // ready_o is a registered copy of "not going to be in SKID".
        ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= decoded_empty('0);
            skid_q  <= decoded_empty('0);
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_o       = ready_q;
    assign valid_o       = (state_q != ST_EMPTY);
    assign pc_o          = main_q.pc;
    assign opcode_o      = main_q.opcode;
    assign rs1_o         = main_q.rs1;
    assign rs2_o         = main_q.rs2;
    assign rd_o          = main_q.rd;
    assign funct3_o      = main_q.funct3;
    assign funct7_o      = main_q.funct7;
    assign immediate_o   = main_q.imm;
    assign imm_fmt_o     = main_q.imm_fmt;
    assign rf_rw_o       = main_q.rf_rw;
    assign err_o         = main_q.err;
    assign illegal_cnt_o = cnt_q;

endmodule
